// File: rtl/burst_pop_pkg.sv
// Shared types and helpers for the burst pop initiator.
package burst_pop_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  // Width of cmd_len for a given maximum burst length.
  function automatic int unsigned len_w(input int unsigned max_burst);
    return (max_burst > 32'd1) ? int'($clog2(max_burst)) : 32'd1;
  endfunction

endpackage

// File: rtl/burst_pop_if.sv
// Command, FIFO-pop and output-stream signals of the burst pop initiator.
interface burst_pop_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_W      = 8
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_W-1:0]      cmd_len;
  logic                  pop_req;
  logic                  pop_ack;
  logic                  pop_ack_pulse;
  logic [DATA_WIDTH-1:0] pop_struct;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  busy;
  logic                  proto_err;

  modport master (
    input  cmd_valid, cmd_len, pop_ack, pop_ack_pulse, pop_struct, m_ready,
    output cmd_ready, pop_req, m_valid, m_data, m_last, busy, proto_err
  );

  modport slave (
    output cmd_valid, cmd_len, pop_ack, pop_ack_pulse, pop_struct, m_ready,
    input  cmd_ready, pop_req, m_valid, m_data, m_last, busy, proto_err
  );
endinterface

// File: rtl/burst_pop_buf.sv
// First-word-fall-through synchronous buffer; read and write may share a cycle even when full.
module burst_pop_buf #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/burst_pop_initiator.sv
// Drains cmd_len+1 words from a FIFO pop port via req/ack and replays them as a valid/ready burst.
module burst_pop_initiator
  import burst_pop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_BURST   = 256,
  parameter int unsigned STREAM_MODE = 1,
  parameter int unsigned BUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  burst_pop_if.master bus
);
  localparam int unsigned LEN_W = len_w(MAX_BURST);
  localparam int unsigned REM_W = LEN_W + 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  state_t           state;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_nxt;
  logic             pop_req;
  logic             cmd_ready;
  logic             busy;
  logic             proto_err;
  logic             cap;
  logic             rd;
  logic             accept;
  logic             credit;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             buf_full;
  logic             buf_empty;
  logic [ENT_W-1:0] buf_dout;

  // Credit is judged on the post-edge occupancy, after this cycle's capture and read.
  always_comb begin
    rd        = bus.m_ready & ~buf_empty;
    cap       = bus.pop_ack_pulse & pop_req & (~buf_full | rd);
    accept    = (state == IDLE) & cmd_ready & bus.cmd_valid;
    rem_nxt   = accept ? REM_W'(bus.cmd_len) + REM_W'(1) : rem - REM_W'(cap);
    count_nxt = count + CNT_W'(cap) - CNT_W'(rd);
    credit    = (rem_nxt != '0) & (count_nxt < CNT_W'(BUF_DEPTH));
  end

  burst_pop_buf #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .wr_en (cap),
    .rd_en (rd),
    .din   ({rem == REM_W'(1), bus.pop_struct}),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      pop_req   <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rem       <= rem_nxt;
      proto_err <= proto_err | (bus.pop_ack_pulse & ~pop_req);
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= REQ;
            pop_req   <= credit;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= (count_nxt != '0);
          end
        end
        REQ: begin
          if ((STREAM_MODE != 0) && (rem_nxt == '0)) begin
            state     <= IDLE;
            pop_req   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= (count_nxt != '0);
          end else if ((STREAM_MODE == 0) && cap) begin
            state   <= ACK_LOW;
            pop_req <= 1'b0;
          end else begin
            pop_req <= credit;
          end
        end
        // Four-phase return-to-zero: the next request waits for ack to fall.
        ACK_LOW: begin
          if (!bus.pop_ack) begin
            if (rem == '0) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= (count_nxt != '0);
            end else begin
              state   <= REQ;
              pop_req <= credit;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pop_req   <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.pop_req   = pop_req;
  assign bus.busy      = busy;
  assign bus.proto_err = proto_err;
  assign bus.m_valid   = ~buf_empty;
  assign bus.m_data    = buf_dout[DATA_WIDTH-1:0];
  assign bus.m_last    = buf_dout[DATA_WIDTH];

endmodule

// File: tb/tb_burst_pop_initiator.sv
// Directed bench: one streaming-mode and one four-phase-mode initiator with simple FIFO responders.
module tb_burst_pop_initiator;
  import burst_pop_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned MAXB = 256;
  localparam int unsigned LW   = len_w(MAXB);
  localparam int unsigned BD   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  burst_pop_if #(.DATA_WIDTH(DW), .LEN_W(LW)) s_if ();
  burst_pop_if #(.DATA_WIDTH(DW), .LEN_W(LW)) f_if ();

  burst_pop_initiator #(.DATA_WIDTH(DW), .MAX_BURST(MAXB), .STREAM_MODE(1), .BUF_DEPTH(BD))
    dut_s (.clk(clk), .reset(reset), .bus(s_if));
  burst_pop_initiator #(.DATA_WIDTH(DW), .MAX_BURST(MAXB), .STREAM_MODE(0), .BUF_DEPTH(BD))
    dut_f (.clk(clk), .reset(reset), .bus(f_if));

  int n_checks = 0;
  int n_pass   = 0;

  // Streaming responder: acks every requesting cycle, data = base + words captured since mark.
  logic        s_auto, s_inject;
  logic [DW-1:0] s_base;
  int unsigned s_caps = 0, s_cap0 = 0, s_req_hi = 0;
  logic [DW:0] s_rx[$];

  always @(posedge clk) begin
    #1;
    s_if.pop_ack_pulse = (s_auto & s_if.pop_req) | s_inject;
    s_if.pop_struct    = s_inject ? 32'hDEAD_BEEF : s_base + DW'(s_caps - s_cap0);
  end

  always @(negedge clk) begin
    if (s_if.pop_ack_pulse && s_if.pop_req) s_caps++;
    if (s_if.pop_req) s_req_hi++;
    if (s_if.m_valid && s_if.m_ready) s_rx.push_back({s_if.m_last, s_if.m_data});
  end

  // Four-phase responder: acks after one extra cycle of req, holds ack 3 cycles.
  int unsigned f_caps = 0, f_req_hi = 0, f_rises = 0, f_viol = 0;
  int          f_lag = 0, f_hold = 0;
  bit          f_req_prev = 1'b0;
  logic [DW:0] f_rx[$];

  always @(posedge clk) begin
    #1;
    f_if.pop_ack_pulse = 1'b0;
    if (reset) begin
      f_if.pop_ack = 1'b0;
      f_lag        = 1;
    end else if (f_if.pop_req && !f_if.pop_ack) begin
      if (f_lag == 0) begin
        f_if.pop_ack       = 1'b1;
        f_if.pop_ack_pulse = 1'b1;
        f_hold             = 2;
        f_lag              = 1;
      end else begin
        f_lag--;
      end
    end else if (f_if.pop_ack) begin
      if (f_hold == 0) f_if.pop_ack = 1'b0;
      else f_hold--;
    end
    f_if.pop_struct = 32'hA0 + DW'(f_caps);
  end

  always @(negedge clk) begin
    if (f_if.pop_ack_pulse && f_if.pop_req) f_caps++;
    if (f_if.pop_req) f_req_hi++;
    if (f_if.pop_req && !f_req_prev) f_rises++;
    if (f_if.pop_req && f_if.pop_ack && !f_if.pop_ack_pulse) f_viol++;
    f_req_prev = f_if.pop_req;
    if (f_if.m_valid && f_if.m_ready) f_rx.push_back({f_if.m_last, f_if.m_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] beat(input bit sel, input int idx);
    if (sel) return (idx < f_rx.size()) ? 64'(f_rx[idx]) : '1;
    return (idx < s_rx.size()) ? 64'(s_rx[idx]) : '1;
  endfunction

  function automatic logic [63:0] exp_beat(input bit last, input logic [DW-1:0] data);
    return 64'({last, data});
  endfunction

  // Called and returns on a falling edge; holds cmd_valid until the command is accepted.
  task automatic send_cmd(input bit sel, input logic [LW-1:0] len, output int waited);
    waited = 0;
    if (sel) begin f_if.cmd_len = len; f_if.cmd_valid = 1'b1; end
    else     begin s_if.cmd_len = len; s_if.cmd_valid = 1'b1; end
    while (((sel ? f_if.cmd_ready : s_if.cmd_ready) !== 1'b1) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_eq("cmd_accept", 64'(sel ? f_if.cmd_ready : s_if.cmd_ready), 64'd1);
    @(negedge clk);
    if (sel) f_if.cmd_valid = 1'b0;
    else     s_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rx(input bit sel, input int n, input string tag);
    int k = 0;
    while (((sel ? f_rx.size() : s_rx.size()) < n) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 64'(sel ? f_rx.size() : s_rx.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int m, q, c, w;
    reset = 1'b1;
    s_if.cmd_valid = 1'b0; s_if.cmd_len = '0; s_if.m_ready = 1'b1;
    f_if.cmd_valid = 1'b0; f_if.cmd_len = '0; f_if.m_ready = 1'b1;
    s_auto = 1'b0; s_inject = 1'b0; s_base = '0;

    // Reset held three cycles, then cmd_ready rises one cycle after release.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_pop_req",   64'(s_if.pop_req),   64'd0);
      check_eq("rst_m_valid",   64'(s_if.m_valid),   64'd0);
      check_eq("rst_cmd_ready", 64'(s_if.cmd_ready), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready_s", 64'(s_if.cmd_ready), 64'd1);
    check_eq("post_rst_cmd_ready_f", 64'(f_if.cmd_ready), 64'd1);
    check_eq("post_rst_busy",        64'(s_if.busy),      64'd0);
    check_eq("post_rst_proto_err",   64'(s_if.proto_err), 64'd0);

    // Streaming 8-beat burst with full acks and an always-ready consumer.
    s_auto = 1'b1; s_base = 32'h10; s_cap0 = s_caps; m = s_rx.size(); q = s_req_hi;
    send_cmd(1'b0, LW'(7), w);
    check_eq("t2_accept_wait", 64'(w), 64'd0);
    wait_rx(1'b0, m + 8, "t2_beats");
    repeat (3) @(negedge clk);
    check_eq("t2_req_cycles", 64'(s_req_hi - q), 64'd8);
    for (int i = 0; i < 8; i++)
      check_eq("t2_beat", beat(1'b0, m + i), exp_beat(i == 7, DW'(32'h10 + i)));
    check_eq("t2_busy",      64'(s_if.busy),      64'd0);
    check_eq("t2_cmd_ready", 64'(s_if.cmd_ready), 64'd1);

    // Backpressure: only BD words may be pulled before the consumer drains.
    s_if.m_ready = 1'b0; s_base = 32'h100; s_cap0 = s_caps; m = s_rx.size();
    send_cmd(1'b0, LW'(15), w);
    repeat (12) @(negedge clk);
    check_eq("t3_captured", 64'(s_caps - s_cap0), 64'(BD));
    check_eq("t3_pop_req",  64'(s_if.pop_req),    64'd0);
    check_eq("t3_m_valid",  64'(s_if.m_valid),    64'd1);
    check_eq("t3_busy",     64'(s_if.busy),       64'd1);
    s_if.m_ready = 1'b1;
    wait_rx(1'b0, m + 16, "t3_beats");
    repeat (4) @(negedge clk);
    check_eq("t3_no_extra", 64'(s_rx.size()), 64'(m + 16));
    for (int i = 0; i < 16; i++)
      check_eq("t3_beat", beat(1'b0, m + i), exp_beat(i == 15, DW'(32'h100 + i)));

    // Four-phase mode, 3 words.
    m = f_rx.size(); q = f_req_hi; c = f_rises;
    send_cmd(1'b1, LW'(2), w);
    wait_rx(1'b1, m + 3, "t4_beats");
    repeat (6) @(negedge clk);
    check_eq("t4_req_cycles", 64'(f_req_hi - q), 64'd6);
    check_eq("t4_req_rises",  64'(f_rises - c),  64'd3);
    check_eq("t4_req_during_ack", 64'(f_viol),   64'd0);
    for (int i = 0; i < 3; i++)
      check_eq("t4_beat", beat(1'b1, m + i), exp_beat(i == 2, DW'(32'hA0 + i)));
    check_eq("t4_busy",      64'(f_if.busy),      64'd0);
    check_eq("t4_cmd_ready", 64'(f_if.cmd_ready), 64'd1);

    // Single-beat command followed immediately by a 2-beat command.
    s_base = 32'h200; s_cap0 = s_caps; m = s_rx.size();
    send_cmd(1'b0, LW'(0), w);
    send_cmd(1'b0, LW'(1), w);
    check_eq("t5_second_wait", 64'(w), 64'd1);
    wait_rx(1'b0, m + 3, "t5_beats");
    check_eq("t5_beat0", beat(1'b0, m),     exp_beat(1'b1, 32'h200));
    check_eq("t5_beat1", beat(1'b0, m + 1), exp_beat(1'b0, 32'h201));
    check_eq("t5_beat2", beat(1'b0, m + 2), exp_beat(1'b1, 32'h202));

    // Unsolicited ack pulse.
    repeat (2) @(negedge clk);
    s_auto = 1'b0;
    @(negedge clk); s_inject = 1'b1;
    @(negedge clk); s_inject = 1'b0;
    @(negedge clk);
    check_eq("t6_proto_err", 64'(s_if.proto_err), 64'd1);
    check_eq("t6_no_capture", 64'(s_if.m_valid),  64'd0);
    s_auto = 1'b1; s_base = 32'h300; s_cap0 = s_caps; m = s_rx.size();
    send_cmd(1'b0, LW'(1), w);
    wait_rx(1'b0, m + 2, "t6_beats");
    repeat (2) @(negedge clk);
    check_eq("t6_beat0", beat(1'b0, m),     exp_beat(1'b0, 32'h300));
    check_eq("t6_beat1", beat(1'b0, m + 1), exp_beat(1'b1, 32'h301));
    check_eq("t6_sticky", 64'(s_if.proto_err), 64'd1);

    // Reset in the middle of an 8-beat burst.
    s_base = 32'h400; s_cap0 = s_caps; m = s_rx.size();
    send_cmd(1'b0, LW'(7), w);
    wait_rx(1'b0, m + 3, "t6_pre_reset_beats");
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_pop_req",   64'(s_if.pop_req),   64'd0);
    check_eq("mid_rst_m_valid",   64'(s_if.m_valid),   64'd0);
    check_eq("mid_rst_busy",      64'(s_if.busy),      64'd0);
    check_eq("mid_rst_proto_err", 64'(s_if.proto_err), 64'd0);
    check_eq("mid_rst_cmd_ready", 64'(s_if.cmd_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("after_rst_cmd_ready", 64'(s_if.cmd_ready), 64'd1);
    s_base = 32'h500; s_cap0 = s_caps; m = s_rx.size();
    send_cmd(1'b0, LW'(3), w);
    wait_rx(1'b0, m + 4, "t6_post_reset_beats");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check_eq("t6_post_beat", beat(1'b0, m + i), exp_beat(i == 3, DW'(32'h500 + i)));
    check_eq("t6_post_no_extra", 64'(s_rx.size()), 64'(m + 4));
    check_eq("t6_post_busy",     64'(s_if.busy),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
